// File: rtl/spi_host_tx.sv
// spi_host_tx: SPI mode-0 initiator feeding the Forth CPU's SPI slave port.
// Bytes arrive on a valid/ready stream and go out MSB first. All bytes up to
// and including the one flagged tx_last share a single nCS-low window. SCK is
// paced from clk by CLKDIV (half-period in clk cycles, >= 1). nCS stays high
// for at least CS_GAP cycles (>= 1) between frames.
//
// Optional build macro SPI_HOST_MISO_EN adds the MISO input and the
// rx_data/rx_valid outputs. MISO is sampled on every SCK rise and the byte is
// presented on the cycle of its final SCK fall. The transmit path is the same
// cycle for cycle with or without the macro.
module spi_host_tx #(
   parameter int CLKDIV = 4,
   parameter int CS_GAP = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic       busy,
   output logic       nCS,
   output logic       SCK,
   output logic       MOSI
`ifdef SPI_HOST_MISO_EN
   ,
   input  logic       MISO,
   output logic [7:0] rx_data,
   output logic       rx_valid
`endif
);

   localparam int DIV_W = $clog2(CLKDIV + 1);
   localparam int GAP_W = $clog2(CS_GAP + 1);
   localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLKDIV - 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CS_GAP - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SHIFT_LO = 3'd1,
      SHIFT_HI = 3'd2,
      WAIT     = 3'd3,
      HOLD     = 3'd4,
      GAP      = 3'd5
   } state_t;

   state_t           state_q;
   logic [7:0]       sh_q;       // MOSI is always sh_q[7]
   logic             last_q;
   logic [2:0]       bit_q;
   logic [DIV_W-1:0] div_q;
   logic [GAP_W-1:0] gap_q;
   logic             ncs_q;
   logic             sck_q;

   logic             accept_d;
   logic             div_done_d;
   logic             sck_rise_d;
   logic             byte_end_d;

   // Handshake and status depend only on state. That makes tx_ready high
   // while reset holds the FSM in IDLE.
   assign tx_ready   = (state_q == IDLE) || (state_q == WAIT);
   assign busy       = (state_q != IDLE);
   assign accept_d   = tx_valid && tx_ready;
   assign div_done_d = (div_q == '0);
   assign sck_rise_d = (state_q == SHIFT_LO) && div_done_d;
   assign byte_end_d = (state_q == SHIFT_HI) && div_done_d && (bit_q == 3'd0);

   assign nCS  = ncs_q;
   assign SCK  = sck_q;
   assign MOSI = sh_q[7];

   // Transfer FSM. All pin outputs are registered here. The divider reloads on
   // every state entry, so each timed state lasts exactly CLKDIV cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         sh_q    <= 8'h00;
         last_q  <= 1'b0;
         bit_q   <= 3'd0;
         div_q   <= '0;
         gap_q   <= '0;
         ncs_q   <= 1'b1;
         sck_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE, WAIT: begin
               // In WAIT, a new byte continues the frame without raising nCS.
               if (accept_d) begin
                  sh_q    <= tx_data;
                  last_q  <= tx_last;
                  bit_q   <= 3'd7;
                  ncs_q   <= 1'b0;
                  div_q   <= DIV_LOAD;
                  state_q <= SHIFT_LO;
               end
            end
            SHIFT_LO: begin
               if (div_done_d) begin
                  sck_q   <= 1'b1;
                  div_q   <= DIV_LOAD;
                  state_q <= SHIFT_HI;
               end else begin
                  div_q <= div_q - 1'b1;
               end
            end
            SHIFT_HI: begin
               if (div_done_d) begin
                  sck_q <= 1'b0;
                  div_q <= DIV_LOAD;
                  if (bit_q != 3'd0) begin
                     // MOSI moves only on this falling edge.
                     sh_q    <= {sh_q[6:0], 1'b0};
                     bit_q   <= bit_q - 3'd1;
                     state_q <= SHIFT_LO;
                  end else begin
                     state_q <= last_q ? HOLD : WAIT;
                  end
               end else begin
                  div_q <= div_q - 1'b1;
               end
            end
            HOLD: begin
               // Keep nCS low for one more half-period after the last fall.
               if (div_done_d) begin
                  ncs_q   <= 1'b1;
                  sh_q    <= 8'h00;
                  gap_q   <= GAP_LOAD;
                  state_q <= GAP;
               end else begin
                  div_q <= div_q - 1'b1;
               end
            end
            GAP: begin
               if (gap_q == '0) begin
                  state_q <= IDLE;
               end else begin
                  gap_q <= gap_q - 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               ncs_q   <= 1'b1;
               sck_q   <= 1'b0;
               sh_q    <= 8'h00;
            end
         endcase
      end
   end

`ifdef SPI_HOST_MISO_EN
   logic [7:0] rx_sh_q;
   logic [7:0] rx_data_q;
   logic       rx_valid_q;

   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;

   // Receive path. Sample MISO as SCK rises, then publish the byte on its final fall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_sh_q    <= 8'h00;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
      end else begin
         rx_valid_q <= byte_end_d;
         if (sck_rise_d) begin
            rx_sh_q <= {rx_sh_q[6:0], MISO};
         end
         if (byte_end_d) begin
            rx_data_q <= rx_sh_q;
         end
      end
   end
`else
   // Without the receive path, these strobes have no consumer.
   logic unused_d;
   assign unused_d = sck_rise_d ^ byte_end_d;
`endif

endmodule

// File: tb/tb_spi_host_tx.sv
// Directed bench for spi_host_tx. Instance A uses CLKDIV=4 and instance B uses
// CLKDIV=1, both with CS_GAP=2. A negedge monitor per instance decodes MOSI on
// SCK rises and counts nCS and tx_ready cycles.
module tb_spi_host_tx;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   logic [7:0] a_data = 8'h00, b_data = 8'h00;
   logic a_valid = 1'b0, a_last = 1'b0, b_valid = 1'b0, b_last = 1'b0;
   logic a_ready, a_busy, a_ncs, a_sck, a_mosi;
   logic b_ready, b_busy, b_ncs, b_sck, b_mosi;
`ifdef SPI_HOST_MISO_EN
   logic       a_miso;
   logic       b_miso;
   logic [7:0] a_rx_data, b_rx_data;
   logic       a_rx_valid, b_rx_valid;
   assign a_miso = 1'b0;
   assign b_miso = b_mosi;
`endif

   spi_host_tx #(.CLKDIV(4), .CS_GAP(2)) u_a (
      .clk(clk), .reset(rst), .tx_data(a_data), .tx_valid(a_valid), .tx_last(a_last),
      .tx_ready(a_ready), .busy(a_busy), .nCS(a_ncs), .SCK(a_sck), .MOSI(a_mosi)
`ifdef SPI_HOST_MISO_EN
      , .MISO(a_miso), .rx_data(a_rx_data), .rx_valid(a_rx_valid)
`endif
   );

   spi_host_tx #(.CLKDIV(1), .CS_GAP(2)) u_b (
      .clk(clk), .reset(rst), .tx_data(b_data), .tx_valid(b_valid), .tx_last(b_last),
      .tx_ready(b_ready), .busy(b_busy), .nCS(b_ncs), .SCK(b_sck), .MOSI(b_mosi)
`ifdef SPI_HOST_MISO_EN
      , .MISO(b_miso), .rx_data(b_rx_data), .rx_valid(b_rx_valid)
`endif
   );

   initial forever #5 clk = ~clk;

   always @(negedge clk) cyc <= cyc + 1;

   // Monitor A: decode bytes, count nCS low/high cycles, and flag MOSI moving during SCK high.
   int a_rises = 0, a_nb = 0, a_bc = 0, a_low = 0, a_high = 0, a_rdy_cs = 0, a_mv = 0;
   int a_lr = 0, a_pmin = 1000, a_pmax = 0;
   logic [7:0] a_sh = 8'h00;
   logic a_sck_p = 1'b0, a_mosi_p = 1'b0;
   logic [7:0] a_bytes [0:15];
   always @(negedge clk) begin
      a_sck_p  <= a_sck;
      a_mosi_p <= a_mosi;
      if (!a_ncs) a_low <= a_low + 1; else a_high <= a_high + 1;
      if (!a_ncs && a_ready) a_rdy_cs <= a_rdy_cs + 1;
      if (a_sck && a_sck_p && (a_mosi !== a_mosi_p)) a_mv <= a_mv + 1;
      if (a_ncs) a_bc <= 0;
      else if (a_sck && !a_sck_p) begin
         a_rises <= a_rises + 1;
         a_lr    <= cyc;
         if (a_bc != 0) begin
            if (cyc - a_lr < a_pmin) a_pmin <= cyc - a_lr;
            if (cyc - a_lr > a_pmax) a_pmax <= cyc - a_lr;
         end
         a_sh <= {a_sh[6:0], a_mosi};
         if (a_bc == 7) begin
            if (a_nb < 16) a_bytes[a_nb[3:0]] <= {a_sh[6:0], a_mosi};
            a_nb <= a_nb + 1;
            a_bc <= 0;
         end else a_bc <= a_bc + 1;
      end
   end

   // Monitor B: the same decoding for the CLKDIV=1 instance.
   int b_rises = 0, b_nb = 0, b_bc = 0, b_low = 0, b_high = 0, b_mv = 0;
   int b_lr = 0, b_pmin = 1000, b_pmax = 0, b_rxv = 0;
   logic [7:0] b_sh = 8'h00;
   logic b_sck_p = 1'b0, b_mosi_p = 1'b0;
   logic [7:0] b_bytes [0:15];
   always @(negedge clk) begin
      b_sck_p  <= b_sck;
      b_mosi_p <= b_mosi;
      if (!b_ncs) b_low <= b_low + 1; else b_high <= b_high + 1;
      if (b_sck && b_sck_p && (b_mosi !== b_mosi_p)) b_mv <= b_mv + 1;
`ifdef SPI_HOST_MISO_EN
      if (b_rx_valid) b_rxv <= b_rxv + 1;
`endif
      if (b_ncs) b_bc <= 0;
      else if (b_sck && !b_sck_p) begin
         b_rises <= b_rises + 1;
         b_lr    <= cyc;
         if (b_bc != 0) begin
            if (cyc - b_lr < b_pmin) b_pmin <= cyc - b_lr;
            if (cyc - b_lr > b_pmax) b_pmax <= cyc - b_lr;
         end
         b_sh <= {b_sh[6:0], b_mosi};
         if (b_bc == 7) begin
            if (b_nb < 16) b_bytes[b_nb[3:0]] <= {b_sh[6:0], b_mosi};
            b_nb <= b_nb + 1;
            b_bc <= 0;
         end else b_bc <= b_bc + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present a byte and return just after the edge that accepts it; tx_valid stays high.
   task automatic send_a(input logic [7:0] d, input logic l);
      int k;
      a_data = d; a_last = l; a_valid = 1'b1;
      k = 0;
      while (a_ready !== 1'b1 && k < 300) begin tick(); k++; end
      chk("a_send_ready_bound", k < 300, 1);
      tick();
   endtask

   task automatic send_b(input logic [7:0] d, input logic l);
      int k;
      b_data = d; b_last = l; b_valid = 1'b1;
      k = 0;
      while (b_ready !== 1'b1 && k < 300) begin tick(); k++; end
      chk("b_send_ready_bound", k < 300, 1);
      tick();
   endtask

   task automatic wait_a_ncs_high(input string tag);
      int k;
      k = 0;
      while (a_ncs !== 1'b1 && k < 500) begin tick(); k++; end
      chk(tag, k < 500, 1);
   endtask

   task automatic wait_a_idle(input string tag);
      int k;
      k = 0;
      while (a_busy !== 1'b0 && k < 500) begin tick(); k++; end
      chk(tag, k < 500, 1);
   endtask

   task automatic wait_b_ncs_high(input string tag);
      int k;
      k = 0;
      while (b_ncs !== 1'b1 && k < 500) begin tick(); k++; end
      chk(tag, k < 500, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, r0, l0, nb0, rdy0, h0, bad;
      // ---- reset state (checked while reset is still asserted)
      tick(); tick();
      chk("rst_ncs", a_ncs, 1);
      chk("rst_sck", a_sck, 0);
      chk("rst_mosi", a_mosi, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_ready", a_ready, 1);
`ifdef SPI_HOST_MISO_EN
      chk("rst_rx_valid", a_rx_valid, 0);
      chk("rst_rx_data", a_rx_data, 8'h00);
`endif
      rst = 1'b0;
      tick();

      // ---- single byte 0xA5, CLKDIV=4
      r0 = a_rises; nb0 = a_nb;
      a_data = 8'hA5; a_last = 1'b1; a_valid = 1'b1;
      chk("t1_ready_idle", a_ready, 1);
      l0 = a_low;
      tick();
      a_valid = 1'b0;
      chk("t1_ncs_fall", a_ncs, 0);
      chk("t1_mosi_bit7", a_mosi, 1);
      chk("t1_busy", a_busy, 1);
      chk("t1_ready_low", a_ready, 0);
      tick(); tick(); tick();
      chk("t1_sck_low_3", a_sck, 0);
      tick();
      chk("t1_sck_first_rise", a_sck, 1);
      k = 0;
      while (a_ncs !== 1'b1 && k < 200) begin tick(); k++; end
      chk("t1_ncs_rise_cycles", k, 64);
      chk("t1_ncs_low_len", a_low - l0, 68);
      chk("t1_gap_busy0", a_busy, 1);
      tick();
      chk("t1_gap_busy1", a_busy, 1);
      tick();
      chk("t1_busy_drop", a_busy, 0);
      chk("t1_rises", a_rises - r0, 8);
      chk("t1_nbytes", a_nb - nb0, 1);
      chk("t1_byte", a_bytes[nb0], 8'hA5);

      // ---- three-byte frame with tx_valid held
      r0 = a_rises; nb0 = a_nb; rdy0 = a_rdy_cs; l0 = a_low;
      send_a(8'h01, 1'b0);
      send_a(8'h80, 1'b0);
      send_a(8'hFF, 1'b1);
      a_valid = 1'b0;
      wait_a_ncs_high("t2_ncs_rise_bound");
      chk("t2_ncs_low_len", a_low - l0, 198);
      chk("t2_rises", a_rises - r0, 24);
      chk("t2_ready_between", a_rdy_cs - rdy0, 2);
      chk("t2_byte0", a_bytes[nb0], 8'h01);
      chk("t2_byte1", a_bytes[nb0 + 1], 8'h80);
      chk("t2_byte2", a_bytes[nb0 + 2], 8'hFF);
      wait_a_idle("t2_idle_bound");

      // ---- starved frame: 0x3C, a 50-cycle stall, then 0xC3
      nb0 = a_nb; l0 = a_low;
      send_a(8'h3C, 1'b0);
      a_valid = 1'b0;
      k = 0;
      while (a_ready !== 1'b1 && k < 300) begin tick(); k++; end
      chk("t3_wait_bound", k < 300, 1);
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (a_ncs !== 1'b0 || a_sck !== 1'b0) bad++;
      end
      chk("t3_stall_ncs_sck_low", bad, 0);
      send_a(8'hC3, 1'b1);
      a_valid = 1'b0;
      wait_a_ncs_high("t3_ncs_rise_bound");
      chk("t3_ncs_low_len", a_low - l0, 183);
      chk("t3_byte0", a_bytes[nb0], 8'h3C);
      chk("t3_byte1", a_bytes[nb0 + 1], 8'hC3);
      wait_a_idle("t3_idle_bound");

      // ---- reset in the middle of 0xFF, then 0x5A
      r0 = a_rises; nb0 = a_nb;
      send_a(8'hFF, 1'b1);
      a_valid = 1'b0;
      k = 0;
      while (a_rises - r0 < 3 && k < 100) begin tick(); k++; end
      chk("t4_third_rise_bound", k < 100, 1);
      chk("t4_sck_high_before", a_sck, 1);
      rst = 1'b1;
      #1;
      chk("t4_rst_ncs", a_ncs, 1);
      chk("t4_rst_sck", a_sck, 0);
      chk("t4_rst_mosi", a_mosi, 0);
      chk("t4_rst_busy", a_busy, 0);
      chk("t4_rst_ready", a_ready, 1);
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("t4_dropped", a_nb - nb0, 0);
      send_a(8'h5A, 1'b1);
      a_valid = 1'b0;
      wait_a_ncs_high("t4_ncs_rise_bound");
      wait_a_idle("t4_idle_bound");
      chk("t4_nbytes", a_nb - nb0, 1);
      chk("t4_byte", a_bytes[nb0], 8'h5A);
      chk("a_mosi_stable_sck_high", a_mv, 0);
      chk("a_sck_period_min", a_pmin, 8);
      chk("a_sck_period_max", a_pmax, 8);

      // ---- CLKDIV=1: two single-byte frames and the gap between them
      nb0 = b_nb; r0 = b_rises;
      send_b(8'h00, 1'b1);
      b_valid = 1'b0;
      wait_b_ncs_high("t5_ncs_rise1_bound");
      h0 = b_high;
      send_b(8'hFF, 1'b1);
      b_valid = 1'b0;
      chk("t5_ncs_gap_len", b_high - h0, 3);
      l0 = b_low;
      wait_b_ncs_high("t5_ncs_rise2_bound");
      chk("t5_ncs_low_len", b_low - l0, 17);
      chk("t5_rises", b_rises - r0, 16);
      chk("t5_byte0", b_bytes[nb0], 8'h00);
      chk("t5_byte1", b_bytes[nb0 + 1], 8'hFF);
      chk("t5_period_min", b_pmin, 2);
      chk("t5_period_max", b_pmax, 2);
      chk("b_mosi_stable_sck_high", b_mv, 0);

`ifdef SPI_HOST_MISO_EN
      // ---- loopback: B's MISO is tied to its MOSI
      r0 = b_rxv;
      send_b(8'h96, 1'b1);
      b_valid = 1'b0;
      wait_b_ncs_high("t6_ncs_rise_bound");
      chk("t6_rx_pulses", b_rxv - r0, 1);
      chk("t6_rx_data", b_rx_data, 8'h96);
`endif

      repeat (4) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
